// File: rtl/uart_tx_feeder.sv
// Debounces four push buttons, queues one byte per press in a FIFO and feeds uart_tx via start/busy.
// Optional echo path (UART_ECHO_EN): bytes strobed in from uart_rx are queued ahead of button bytes.
module uart_tx_feeder #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter logic [7:0]  BASE_CHAR       = 8'h61
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [3:0]                    btn_i,
   input  logic                          tx_busy_i,
   output logic                          tx_start_o,
   output logic [7:0]                    tx_data_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          overflow_o
`ifdef UART_ECHO_EN
   ,
   input  logic                          rx_valid_i,
   input  logic [7:0]                    rx_data_i
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [3:0]    sync1_q, sync2_q, stable_q, stable_d, press_c;
   logic [DW-1:0] db_cnt_q [4];
   logic [DW-1:0] db_cnt_d [4];
   logic [3:0]    pend_q, pend_d, served_c;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          push_c, pop_c, wr_en_c, full_c, rx_take_c;
   logic [7:0]    push_byte_c, rx_byte_c;
   state_t        state_q, state_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;

`ifdef UART_ECHO_EN
   assign rx_take_c = rx_valid_i;
   assign rx_byte_c = rx_data_i;
`else
   assign rx_take_c = 1'b0;
   assign rx_byte_c = 8'h00;
`endif

   // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
         end
      end
      press_c = stable_d & ~stable_q;
   end

   // One push per cycle: echo byte first, then the lowest-index pending button
   always_comb begin
      push_c      = 1'b0;
      push_byte_c = 8'h00;
      served_c    = 4'b0000;
      if (rx_take_c) begin
         push_c      = 1'b1;
         push_byte_c = rx_byte_c;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!push_c && pend_q[i]) begin
               push_c      = 1'b1;
               push_byte_c = BASE_CHAR + 8'(i);
               served_c[i] = 1'b1;
            end
         end
      end
      pend_d = (pend_q & ~served_c) | press_c;
   end

   // FIFO bookkeeping; a push into a full FIFO only lands if a pop frees a slot this cycle
   always_comb begin
      full_c     = (count_q == FULL_CNT);
      wr_en_c    = push_c && (!full_c || pop_c);
      overflow_d = overflow_q | (push_c && full_c && !pop_c);
      count_d    = count_q;
      case ({wr_en_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // TX handshake FSM: next state and registered-output next values
   always_comb begin
      state_d    = state_q;
      pop_c      = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if ((count_q != '0) && !tx_busy_i) begin
               pop_c      = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
               state_d    = ST_ACK;
            end
         end
         ST_ACK:  if (tx_busy_i)  state_d = ST_DONE;
         ST_DONE: if (!tx_busy_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         pend_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         pend_q     <= pend_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_byte_c;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   assign tx_start_o   = tx_start_q;
   assign tx_data_o    = tx_data_q;
   assign fifo_count_o = count_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4) with a simple uart_tx busy model.
// Echo scenario runs only when UART_ECHO_EN is defined.
module tb_uart_tx_feeder;

   localparam int unsigned DC       = 4;
   localparam int unsigned FD       = 4;
   localparam int          BUSY_LEN = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       hold_busy;
   logic       model_en;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [2:0] fifo_count;
   logic       overflow;
`ifdef UART_ECHO_EN
   logic       rx_valid;
   logic [7:0] rx_data;
`endif

   int         busy_cnt   = 0;
   int         start_viol = 0;
   logic [7:0] got[$];
   int         n_checks   = 0;
   int         n_fail     = 0;
   int         base;

   always #5 clk = ~clk;

   uart_tx_feeder #(
      .DEBOUNCE_CYCLES(DC),
      .FIFO_DEPTH     (FD),
      .BASE_CHAR      (8'h61)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_i       (btn),
      .tx_busy_i   (tx_busy),
      .tx_start_o  (tx_start),
      .tx_data_o   (tx_data),
      .fifo_count_o(fifo_count),
      .overflow_o  (overflow)
`ifdef UART_ECHO_EN
      ,
      .rx_valid_i  (rx_valid),
      .rx_data_i   (rx_data)
`endif
   );

   // uart_tx stand-in: busy for BUSY_LEN cycles after each start, plus a manual hold
   assign tx_busy = hold_busy | (busy_cnt != 0);

   always @(posedge clk) begin
      if (tx_start && model_en) busy_cnt <= BUSY_LEN;
      else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) begin
      if (tx_start) begin
         got.push_back(tx_data);
         if (tx_busy) start_viol <= start_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] mask, input int n);
      btn = mask;
      tick(n);
      btn = 4'b0000;
   endtask

   function automatic logic [31:0] got_at(input int idx);
      if (idx < got.size()) return 32'(got[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seq [6];
      rst       = 1'b1;
      btn       = 4'b0000;
      hold_busy = 1'b0;
      model_en  = 1'b1;
`ifdef UART_ECHO_EN
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
`endif
      tick(3);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick(2);

      // Single press of btn[2]
      base = got.size();
      press(4'b0100, 10);
      tick(40);
      check("single_n", 32'(got.size() - base), 32'd1);
      check("single_byte", got_at(base), 32'h63);
      check("single_count", 32'(fifo_count), 32'd0);

      // Bounce on btn[0] never settles long enough
      base = got.size();
      for (int k = 0; k < 10; k++) begin
         btn[0] = ~btn[0];
         tick(2);
      end
      btn = 4'b0000;
      tick(30);
      check("bounce_n", 32'(got.size() - base), 32'd0);
      check("bounce_count", 32'(fifo_count), 32'd0);

      // Simultaneous press of btn 0,1,3
      base = got.size();
      press(4'b1011, 10);
      tick(80);
      check("simul_n", 32'(got.size() - base), 32'd3);
      check("simul_b0", got_at(base), 32'h61);
      check("simul_b1", got_at(base + 1), 32'h62);
      check("simul_b2", got_at(base + 2), 32'h64);
      check("simul_wait_busy", 32'(start_viol), 32'd0);

      // Overflow: six presses with the transmitter held busy
      base = got.size();
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      hold_busy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         press(seq[k], 10);
         tick(10);
      end
      tick(10);
      check("ovf_count", 32'(fifo_count), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_none_sent", 32'(got.size() - base), 32'd0);
      hold_busy = 1'b0;
      tick(100);
      check("ovf_n", 32'(got.size() - base), 32'd4);
      check("ovf_b0", got_at(base), 32'h61);
      check("ovf_b1", got_at(base + 1), 32'h62);
      check("ovf_b2", got_at(base + 2), 32'h63);
      check("ovf_b3", got_at(base + 3), 32'h64);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_drained", 32'(fifo_count), 32'd0);

      // Reset while waiting in ACK with three bytes still queued
      base = got.size();
      hold_busy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         press(seq[k], 10);
         tick(10);
      end
      tick(10);
      check("mid_full", 32'(fifo_count), 32'd4);
      model_en  = 1'b0;
      hold_busy = 1'b0;
      tick(3);
      check("mid_one_sent", 32'(got.size() - base), 32'd1);
      check("mid_byte", got_at(base), 32'h61);
      check("mid_count3", 32'(fifo_count), 32'd3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_start", 32'(tx_start), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      model_en = 1'b1;
      tick(30);
      check("mid_no_more", 32'(got.size() - base), 32'd1);

`ifdef UART_ECHO_EN
      // Echo byte collides with btn[1]'s press event and takes the slot first
      base = got.size();
      btn = 4'b0010;
      tick(6);
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      tick(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(4);
      btn = 4'b0000;
      tick(60);
      check("echo_n", 32'(got.size() - base), 32'd2);
      check("echo_b0", got_at(base), 32'h5A);
      check("echo_b1", got_at(base + 1), 32'h62);
`endif

      check("final_wait_busy", 32'(start_viol), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
